// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
//   Shared types and helpers for the UART transmit arbiter.
//   - arb_state_t : arbiter FSM states
//   - UART_DATA_W : default byte width presented to the serializer
//   - RR_MAX_N    : widest requester vector rr_pick handles
//   - rr_pick     : round-robin winner search, returns a one-hot vector
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    LAUNCH,
    WAIT_DONE
  } arb_state_t;

  localparam int UART_DATA_W = 8;
  localparam int RR_MAX_N    = 8;

  // Search upward from ptr+1 (mod n) and return the first set request
  // as a one-hot vector. Only the low n bits of req are considered.
  function automatic logic [RR_MAX_N-1:0] rr_pick(input logic [RR_MAX_N-1:0] req,
                                                  input int n,
                                                  input int ptr);
    logic [RR_MAX_N-1:0] win;
    int idx;
    win = '0;
    for (int k = 1; k <= RR_MAX_N; k++) begin
      if (k <= n) begin
        idx = (ptr + k) % n;
        if (win == '0 && req[idx]) win[idx] = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Requester and serializer signals of the UART transmit arbiter.
//   req_valid/req_data/req_last/req_ready : per-requester byte stream
//   grant/active_id                        : current owner
//   tx_start/tx_data/tx_busy/tx_done       : serializer handshake
//   timeout_err                            : watchdog revocation pulse
//   Modports: slave (the arbiter), master (requesters + serializer side).
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = UART_DATA_W
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        grant;
  logic [IW-1:0]             active_id;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic                      tx_done;
  logic                      timeout_err;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy, tx_done,
    output req_ready, grant, active_id, tx_start, tx_data, timeout_err
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy, tx_done,
    input  req_ready, grant, active_id, tx_start, tx_data, timeout_err
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick among N requests, starting the search
//   just above ptr.
//   req     : request vector
//   ptr     : index of the most recent owner (lowest priority)
//   gnt     : one-hot winner, zero when no request is set
//   gnt_idx : index of the winner, zero when no request is set
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [RR_MAX_N-1:0] req_pad;
  logic [RR_MAX_N-1:0] pick;

  always_comb begin
    req_pad        = '0;
    req_pad[N-1:0] = req;
    pick           = rr_pick(req_pad, N, int'(ptr));
    gnt            = pick[N-1:0];
    gnt_idx        = '0;
    for (int i = 0; i < RR_MAX_N; i++) begin
      if (pick[i]) gnt_idx = IW'(i);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART serializer between NUM_REQ byte-stream requesters with
//   packet-granular round-robin arbitration and a stall watchdog.
//   clk, rst : clock, synchronous active-high reset
//   bus      : uart_tx_arbiter_if.slave (requester streams, grant/active_id,
//              serializer start/data/busy/done, timeout_err)
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = UART_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic             clk,
  input logic             rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IW-1:0]       id_q, id_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic                tx_start_q, tx_start_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                last_q, last_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic                terr_q, terr_d;
  logic [NUM_REQ-1:0]  req_ready;
  logic [NUM_REQ-1:0]  win;
  logic [IW-1:0]       win_idx;
  logic                accept;

  // The stall counter holds at all-ones instead of wrapping.
  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .gnt     (win),
    .gnt_idx (win_idx)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    terr_d     = 1'b0;
    req_ready  = '0;
    if (state_q == LOAD && !bus.tx_busy) req_ready = grant_q & bus.req_valid;
    accept = |req_ready;

    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          grant_d = win;
          id_d    = win_idx;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          tx_data_d  = bus.req_data[id_q*DATA_W +: DATA_W];
          last_d     = bus.req_last[id_q];
          tx_start_d = 1'b1;
          cnt_d      = '0;
          state_d    = LAUNCH;
        end else if (!bus.req_valid[id_q]) begin
          if (WD_EN && cnt_q == TO_LAST) begin
            // Stalled owner: revoke and drop it to lowest priority.
            terr_d  = 1'b1;
            grant_d = '0;
            id_d    = '0;
            ptr_d   = id_q;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
      end
      LAUNCH, WAIT_DONE: begin
        // tx_done is honoured in LAUNCH too, for serializers that finish
        // before busy is ever observed.
        if (bus.tx_done) begin
          if (last_q) begin
            grant_d = '0;
            id_d    = '0;
            ptr_d   = id_q;
            state_d = IDLE;
          end else begin
            state_d = LOAD;
          end
        end else if (state_q == LAUNCH && bus.tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      id_q       <= '0;
      ptr_q      <= IW'(NUM_REQ - 1);
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      terr_q     <= terr_d;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.grant       = grant_q;
  assign bus.active_id   = id_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter: queued requester streams, a
//   10-cycle serializer model and hand-computed expectations.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int DATA_W   = 8;
  localparam int TO       = 16;
  localparam int BUSY_LEN = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // requester queues: main writes rmem/rtail, model advances rhead
  logic [8:0] rmem [NUM_REQ][32];
  int rhead [NUM_REQ];
  int rtail [NUM_REQ];
  logic [NUM_REQ-1:0] acc;

  // serializer model state and logs (written only by the model block)
  int cyc = 0;
  int ser_cnt = 0;
  logic [7:0] ser_byte = 8'h00;
  int done_cnt = 0, done_cyc = 0;
  int terr_cnt = 0, terr_cyc = 0;
  logic [NUM_REQ-1:0] terr_grant = '0;
  int unstable = 0;
  int n_st = 0;
  logic [7:0] st_data [64];
  int st_id [64];
  logic ser_force = 1'b0;

  logic [NUM_REQ-1:0] m_v, m_l;
  logic [NUM_REQ*DATA_W-1:0] m_d;

  int n_vec = 0, n_mis = 0;
  int base = 0;

  always @(negedge clk) acc = bus.req_ready & bus.req_valid;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    for (int i = 0; i < NUM_REQ; i++)
      if (acc[i] && rhead[i] < rtail[i]) rhead[i] = rhead[i] + 1;
    m_v = '0; m_l = '0; m_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rhead[i] < rtail[i]) begin
        m_v[i] = 1'b1;
        m_d[i*DATA_W +: DATA_W] = rmem[i][rhead[i]][7:0];
        m_l[i] = rmem[i][rhead[i]][8];
      end
    end
    bus.req_valid = m_v;
    bus.req_data  = m_d;
    bus.req_last  = m_l;
    if (bus.tx_start) begin
      st_data[n_st] = bus.tx_data;
      st_id[n_st]   = int'(bus.active_id);
      n_st = n_st + 1;
    end
    if (bus.timeout_err) begin
      terr_cnt   = terr_cnt + 1;
      terr_cyc   = cyc;
      terr_grant = bus.grant;
    end
    bus.tx_done = 1'b0;
    if (ser_force) begin
      bus.tx_busy = 1'b1;
    end else if (ser_cnt > 0) begin
      if (bus.tx_data != ser_byte) unstable = unstable + 1;
      ser_cnt = ser_cnt - 1;
      if (ser_cnt == 0) begin
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b1;
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
    end else begin
      bus.tx_busy = 1'b0;
      if (bus.tx_start) begin
        bus.tx_busy = 1'b1;
        ser_cnt  = BUSY_LEN;
        ser_byte = bus.tx_data;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    rmem[r][rtail[r]] = {l, d};
    rtail[r] = rtail[r] + 1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) rtail[i] = rhead[i];
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = n_st;
  endtask

  task automatic wait_grant(input logic [NUM_REQ-1:0] exp, input int budget, input string tag);
    int k = 0;
    while (bus.grant !== exp && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(bus.grant), 32'(exp));
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    int k = 0;
    while (n_st - base < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, n_st - base, n);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d0, t0, bad;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_active_id", 32'(bus.active_id), 0);
    chk("rst_tx_start", 32'(bus.tx_start), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    rst = 1'b0;
    @(negedge clk);

    // single byte from requester 2
    do_reset();
    push(2, 8'h5A, 1'b1);
    @(negedge clk);
    chk("t1_grant_pre", 32'(bus.grant), 0);
    @(negedge clk);
    chk("t1_grant", 32'(bus.grant), 32'h4);
    chk("t1_active_id", 32'(bus.active_id), 2);
    wait_starts(1, 10, "t1_start");
    chk("t1_tx_data", 32'(st_data[base]), 32'h5A);
    chk("t1_start_id", st_id[base], 2);
    wait_grant('0, 40, "t1_release");
    chk("t1_release_lat", cyc - done_cyc, 1);
    chk("t1_one_start", n_st - base, 1);

    // three requesters, round-robin order and pointer advance
    do_reset();
    push(0, 8'hA0, 1'b1);
    push(1, 8'hA1, 1'b1);
    push(3, 8'hA3, 1'b1);
    wait_starts(3, 100, "t2_round1");
    wait_grant('0, 40, "t2_round1_idle");
    chk("t2_order0", st_id[base], 0);
    chk("t2_order1", st_id[base+1], 1);
    chk("t2_order2", st_id[base+2], 3);
    push(0, 8'hC0, 1'b1);
    wait_starts(4, 40, "t2_c0");
    wait_grant('0, 40, "t2_c0_idle");
    push(0, 8'hD0, 1'b1);
    push(1, 8'hD1, 1'b1);
    wait_starts(6, 80, "t2_round2");
    wait_grant('0, 40, "t2_round2_idle");
    chk("t2_ptr_first", st_id[base+4], 1);
    chk("t2_ptr_second", st_id[base+5], 0);
    chk("t2_ptr_data", 32'(st_data[base+4]), 32'hD1);

    // 3-byte packet holds the grant against a competing requester
    do_reset();
    push(1, 8'h11, 1'b0);
    push(1, 8'h22, 1'b0);
    push(1, 8'h33, 1'b1);
    wait_grant(4'b0010, 5, "t3_grant1");
    push(0, 8'h44, 1'b1);
    d0 = done_cnt;
    k = 0;
    while (bus.grant == 4'b0010 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t3_frames_held", n_st - base, 3);
    chk("t3_dones_held", done_cnt - d0, 3);
    chk("t3_gap_grant", 32'(bus.grant), 0);
    wait_grant(4'b0001, 3, "t3_grant0");
    wait_starts(4, 40, "t3_all");
    wait_grant('0, 40, "t3_idle");
    chk("t3_b0", 32'(st_data[base]), 32'h11);
    chk("t3_b1", 32'(st_data[base+1]), 32'h22);
    chk("t3_b2", 32'(st_data[base+2]), 32'h33);
    chk("t3_b3", 32'(st_data[base+3]), 32'h44);
    chk("t3_b3_id", st_id[base+3], 0);

    // watchdog revokes a stalled owner
    do_reset();
    t0 = terr_cnt;
    push(0, 8'h01, 1'b0);
    wait_grant(4'b0001, 5, "t4_grant0");
    push(1, 8'h77, 1'b1);
    k = 0;
    while (terr_cnt == t0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t4_terr_seen", terr_cnt - t0, 1);
    chk("t4_terr_lat", terr_cyc - (done_cyc + 1), 16);
    chk("t4_terr_grant", 32'(terr_grant), 0);
    @(negedge clk);
    chk("t4_terr_pulse", 32'(bus.timeout_err), 0);
    wait_grant(4'b0010, 5, "t4_grant1");
    wait_starts(2, 40, "t4_starts");
    wait_grant('0, 40, "t4_idle");
    chk("t4_byte1", 32'(st_data[base+1]), 32'h77);
    chk("t4_single_terr", terr_cnt - t0, 1);

    // serializer busy on entry to LOAD
    do_reset();
    ser_force = 1'b1;
    push(3, 8'hC3, 1'b1);
    wait_grant(4'b1000, 5, "t5_grant3");
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.req_ready != '0 || bus.tx_start) bad++;
    end
    chk("t5_stalled", bad, 0);
    chk("t5_no_start", n_st - base, 0);
    ser_force = 1'b0;
    @(negedge clk);
    chk("t5_ready_same_cycle", 32'(bus.req_ready), 32'h8);
    wait_starts(1, 5, "t5_start");
    wait_grant('0, 40, "t5_idle");
    chk("t5_byte", 32'(st_data[base]), 32'hC3);

    chk("tx_data_hold", unstable, 0);

    // reset during WAIT_DONE of a 2-byte packet
    do_reset();
    push(0, 8'hE1, 1'b0);
    push(0, 8'hE2, 1'b1);
    wait_starts(1, 20, "t6_start");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) rtail[i] = rhead[i];
    @(negedge clk);
    chk("t6_grant", 32'(bus.grant), 0);
    chk("t6_active_id", 32'(bus.active_id), 0);
    chk("t6_tx_start", 32'(bus.tx_start), 0);
    chk("t6_tx_data", 32'(bus.tx_data), 0);
    chk("t6_timeout_err", 32'(bus.timeout_err), 0);
    chk("t6_req_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t6_stray_done", done_cnt - d0, 1);
    @(negedge clk);
    chk("t6_stray_grant", 32'(bus.grant), 0);
    chk("t6_stray_start", n_st - base, 1);
    push(1, 8'hF1, 1'b1);
    push(0, 8'hF0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t6_first_after_rst", 32'(bus.grant), 32'h1);
    wait_starts(3, 60, "t6_starts");
    wait_grant('0, 40, "t6_idle");
    chk("t6_id_a", st_id[base+1], 0);
    chk("t6_id_b", st_id[base+2], 1);
    chk("t6_data_a", 32'(st_data[base+1]), 32'hF0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
